// File: rtl/panel_init_pkg.sv
// Shared opcodes, entry field positions and FSM encoding for the panel init sequencer.
package panel_init_pkg;

   localparam logic [1:0] OP_CMD   = 2'd0;
   localparam logic [1:0] OP_DELAY = 2'd1;
   localparam logic [1:0] OP_END   = 2'd2;
   localparam logic [1:0] OP_RSVD  = 2'd3;

   // Entry layout: {op[15:14], arg[13:0]}; CMD arg = {nparam[13:8], dcs[7:0]}
   localparam int OP_MSB   = 15;
   localparam int OP_LSB   = 14;
   localparam int ARG_MSB  = 13;
   localparam int ARG_LSB  = 0;
   localparam int NPAR_MSB = 13;
   localparam int NPAR_LSB = 8;
   localparam int DCS_MSB  = 7;
   localparam int DCS_LSB  = 0;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_SEND_CMD,
      S_PFETCH,
      S_SEND_PARAM,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_t;

endpackage

// File: rtl/init_delay_timer.sv
// Two-level delay timer: a unit counter of DELAY_UNIT cycles nested under a tick counter.
// o_expired pulses on the last cycle of an arg*DELAY_UNIT cycle wait started by i_load.
module init_delay_timer #(
   parameter int DELAY_UNIT = 1000,
   parameter int DELAY_W    = 14
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic [DELAY_W-1:0] i_arg,
   output logic               o_expired
);

   localparam int UNIT_W = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
   localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(DELAY_UNIT - 1);

   logic [UNIT_W-1:0]  r_unit;
   logic [DELAY_W-1:0] r_ticks;
   logic               r_active;
   logic               w_unit_wrap;

   assign w_unit_wrap = (r_unit == UNIT_LAST);
   assign o_expired   = r_active && w_unit_wrap && (r_ticks == DELAY_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_unit   <= '0;
         r_ticks  <= '0;
         r_active <= 1'b0;
      end else if (i_load) begin
         r_unit   <= '0;
         r_ticks  <= i_arg;
         r_active <= (i_arg != '0);
      end else if (r_active) begin
         if (w_unit_wrap) begin
            r_unit  <= '0;
            r_ticks <= r_ticks - DELAY_W'(1);
            if (r_ticks == DELAY_W'(1))
               r_active <= 1'b0;
         end else begin
            r_unit <= r_unit + UNIT_W'(1);
         end
      end
   end

endmodule

// File: rtl/panel_init_sequencer.sv
// Walks the panel init command table in RAM and streams DCS command packets to the DSI TX path.
// Optional XOR checksum of transferred bytes: define PANEL_INIT_SEQ_CHECKSUM_EN.
module panel_init_sequencer
   import panel_init_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int RD_LATENCY = 1,
   parameter int DELAY_UNIT = 1000,
   parameter int DELAY_W    = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [15:0]           ram_rdata,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_first,
   output logic                  tx_last,
   output logic                  busy,
   output logic                  done,
   output logic                  error
`ifdef PANEL_INIT_SEQ_CHECKSUM_EN
   ,
   output logic [7:0]            seq_checksum
`endif
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   state_t                r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_lat;
   logic [7:0]            r_cmd;
   logic [5:0]            r_pcnt;
   logic                  r_done, r_error;
   logic                  w_lat_done, w_xfer, w_at_end, w_addr_inc;
   logic                  w_timer_load, w_timer_expired;
   logic [1:0]            w_op;
   logic [DELAY_W-1:0]    w_arg;

   assign w_op       = ram_rdata[OP_MSB:OP_LSB];
   assign w_arg      = DELAY_W'(ram_rdata[ARG_MSB:ARG_LSB]);
   assign w_lat_done = (r_lat == 2'(RD_LATENCY - 1));
   assign w_xfer     = tx_valid && tx_ready;
   assign w_at_end   = (r_addr == LAST_ADDR);

   init_delay_timer #(
      .DELAY_UNIT (DELAY_UNIT),
      .DELAY_W    (DELAY_W)
   ) u_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_timer_load),
      .i_arg     (w_arg),
      .o_expired (w_timer_expired)
   );

   // Every "advance to next entry" goes through the overrun check: no address wrap.
   always_comb begin
      w_next       = r_state;
      w_addr_inc   = 1'b0;
      w_timer_load = 1'b0;
      case (r_state)
         S_IDLE:   if (start) w_next = S_FETCH;
         S_FETCH:  if (w_lat_done) w_next = S_DECODE;
         S_DECODE: begin
            case (w_op)
               OP_CMD:   w_next = S_SEND_CMD;
               OP_DELAY: begin
                  if (w_arg != '0) begin
                     w_next       = S_WAIT;
                     w_timer_load = 1'b1;
                  end else if (w_at_end) begin
                     w_next = S_ERR;
                  end else begin
                     w_next     = S_FETCH;
                     w_addr_inc = 1'b1;
                  end
               end
               OP_END:   w_next = S_DONE;
               OP_RSVD:  w_next = S_ERR;
               default:  w_next = S_ERR;
            endcase
         end
         S_SEND_CMD: begin
            if (w_xfer) begin
               if (w_at_end) begin
                  w_next = S_ERR;
               end else begin
                  w_next     = (r_pcnt == 6'd0) ? S_FETCH : S_PFETCH;
                  w_addr_inc = 1'b1;
               end
            end
         end
         S_PFETCH: if (w_lat_done) w_next = S_SEND_PARAM;
         S_SEND_PARAM: begin
            if (w_xfer) begin
               if (w_at_end) begin
                  w_next = S_ERR;
               end else begin
                  w_next     = (r_pcnt == 6'd1) ? S_FETCH : S_PFETCH;
                  w_addr_inc = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (w_timer_expired) begin
               if (w_at_end) begin
                  w_next = S_ERR;
               end else begin
                  w_next     = S_FETCH;
                  w_addr_inc = 1'b1;
               end
            end
         end
         S_DONE:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_lat   <= '0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && start)
            r_addr <= '0;
         else if (w_addr_inc)
            r_addr <= r_addr + ADDR_WIDTH'(1);
         if ((r_state == S_FETCH || r_state == S_PFETCH) && !w_lat_done)
            r_lat <= r_lat + 2'd1;
         else
            r_lat <= '0;
         if (r_state == S_IDLE && start) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
         end else if (w_next == S_DONE) begin
            r_done <= 1'b1;
         end else if (w_next == S_ERR) begin
            r_error <= 1'b1;
         end
      end
   end

   // Command byte and remaining parameter count, captured at decode
   always_ff @(posedge clk) begin
      if (r_state == S_DECODE) begin
         r_cmd  <= ram_rdata[DCS_MSB:DCS_LSB];
         r_pcnt <= ram_rdata[NPAR_MSB:NPAR_LSB];
      end else if (r_state == S_SEND_PARAM && w_xfer) begin
         r_pcnt <= r_pcnt - 6'd1;
      end
   end

   // Parameter bytes come straight from the RAM port; the address is held until the
   // byte transfers, so the read data stays stable through a stall.
   always_comb begin
      tx_data = 8'h00;
      case (r_state)
         S_SEND_CMD:   tx_data = r_cmd;
         S_SEND_PARAM: tx_data = ram_rdata[DCS_MSB:DCS_LSB];
         default:      tx_data = 8'h00;
      endcase
   end

   assign tx_valid = (r_state == S_SEND_CMD) || (r_state == S_SEND_PARAM);
   assign tx_first = (r_state == S_SEND_CMD);
   assign tx_last  = ((r_state == S_SEND_CMD) && (r_pcnt == 6'd0)) ||
                     ((r_state == S_SEND_PARAM) && (r_pcnt == 6'd1));
   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign error    = r_error;
   assign ram_addr = r_addr;

`ifdef PANEL_INIT_SEQ_CHECKSUM_EN
   logic [7:0] r_csum;

   // No transfers occur between done/error and the next start, so the value freezes there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_csum <= 8'h00;
      else if (r_state == S_IDLE && start)
         r_csum <= 8'h00;
      else if (w_xfer)
         r_csum <= r_csum ^ tx_data;
   end

   assign seq_checksum = r_csum;
`endif

endmodule

// File: tb/tb_panel_init_sequencer.sv
// Directed bench for panel_init_sequencer: one instance with RD_LATENCY=1, one with RD_LATENCY=2.
module tb_panel_init_sequencer;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          tx_ready = 1'b0;
   logic          sel = 1'b0;

   logic [15:0]   mem1 [16];
   logic [15:0]   mem2 [16];
   logic [15:0]   q2a;

   logic [AW-1:0] addr1, addr2;
   logic [15:0]   rdata1, rdata2;
   logic          v1, v2, f1, f2, l1, l2, b1, b2, d1, d2, e1, e2;
   logic [7:0]    dat1, dat2;
   logic [7:0]    cs1, cs2;

   logic          m_valid, m_first, m_last, m_busy, m_done, m_err;
   logic [7:0]    m_data, m_csum;
   logic [AW-1:0] m_addr;

   int            n_vec = 0;
   int            n_fail = 0;
   int            nb;
   logic [9:0]    got [20];

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      rdata1 <= mem1[addr1];
      q2a    <= mem2[addr2];
      rdata2 <= q2a;
   end

   panel_init_sequencer #(.ADDR_WIDTH(AW), .RD_LATENCY(1), .DELAY_UNIT(4), .DELAY_W(14)) dut (
      .clk(clk), .rst_n(rst_n), .start(start && !sel), .ram_addr(addr1), .ram_rdata(rdata1),
      .tx_valid(v1), .tx_ready(tx_ready), .tx_data(dat1), .tx_first(f1), .tx_last(l1),
      .busy(b1), .done(d1), .error(e1)
`ifdef PANEL_INIT_SEQ_CHECKSUM_EN
      , .seq_checksum(cs1)
`endif
   );

   panel_init_sequencer #(.ADDR_WIDTH(AW), .RD_LATENCY(2), .DELAY_UNIT(4), .DELAY_W(14)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start && sel), .ram_addr(addr2), .ram_rdata(rdata2),
      .tx_valid(v2), .tx_ready(tx_ready), .tx_data(dat2), .tx_first(f2), .tx_last(l2),
      .busy(b2), .done(d2), .error(e2)
`ifdef PANEL_INIT_SEQ_CHECKSUM_EN
      , .seq_checksum(cs2)
`endif
   );

`ifndef PANEL_INIT_SEQ_CHECKSUM_EN
   assign cs1 = 8'h00;
   assign cs2 = 8'h00;
`endif

   assign m_valid = sel ? v2   : v1;
   assign m_data  = sel ? dat2 : dat1;
   assign m_first = sel ? f2   : f1;
   assign m_last  = sel ? l2   : l1;
   assign m_busy  = sel ? b2   : b1;
   assign m_done  = sel ? d2   : d1;
   assign m_err   = sel ? e2   : e1;
   assign m_addr  = sel ? addr2 : addr1;
   assign m_csum  = sel ? cs2  : cs1;

   typedef struct packed {
      logic          start;
      logic          ready;
      logic          valid;
      logic [7:0]    data;
      logic          first;
      logic          last;
      logic          busy;
      logic          done;
      logic          err;
      logic [AW-1:0] addr;
   } vec_t;

   vec_t vt [18];

   function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d, input logic fi,
                               input logic la, input logic bu, input logic dn, input logic er,
                               input logic [AW-1:0] a);
      vec_t r;
      r.start = s;  r.ready = 1'b1; r.valid = v; r.data = d; r.first = fi; r.last = la;
      r.busy  = bu; r.done = dn;    r.err = er;  r.addr = a;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   task automatic load_param_table(input bit which);
      for (int i = 0; i < 16; i++) begin
         if (which) mem2[i] = 16'h8000; else mem1[i] = 16'h8000;
      end
      if (which) begin
         mem2[0] = 16'h02B0; mem2[1] = 16'h0012; mem2[2] = 16'h0034; mem2[3] = 16'h8000;
      end else begin
         mem1[0] = 16'h02B0; mem1[1] = 16'h0012; mem1[2] = 16'h0034; mem1[3] = 16'h8000;
      end
   endtask

   // Pulses start, then runs until busy drops; records {data, first, last} of each transfer.
   task automatic run_stream(input bit toggle, input int max_cyc);
      logic       stalled;
      logic [10:0] held;
      nb       = 0;
      stalled  = 1'b0;
      held     = '0;
      @(negedge clk);
      start    = 1'b1;
      tx_ready = toggle ? 1'b0 : 1'b1;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (stalled) chk("stall_hold", {21'd0, m_valid, m_data, m_first, m_last}, {21'd0, held});
         if (!m_busy) break;
         tx_ready = toggle ? ~tx_ready : 1'b1;
         stalled  = m_valid && !tx_ready;
         held     = {m_valid, m_data, m_first, m_last};
         if (m_valid && tx_ready && nb < 20) begin
            got[nb] = {m_data, m_first, m_last};
            nb++;
         end
      end
      chk("stream_terminates", {31'd0, m_busy}, 32'd0);
   endtask

   task automatic check_b0_stream(input string tag);
      chk({tag, "_nbytes"}, nb, 3);
      chk({tag, "_byte0"}, {22'd0, got[0]}, {22'd0, 8'hB0, 1'b1, 1'b0});
      chk({tag, "_byte1"}, {22'd0, got[1]}, {22'd0, 8'h12, 1'b0, 1'b0});
      chk({tag, "_byte2"}, {22'd0, got[2]}, {22'd0, 8'h34, 1'b0, 1'b1});
      chk({tag, "_done_err"}, {30'd0, m_done, m_err}, {30'd0, 1'b1, 1'b0});
   endtask

   initial begin
      logic [31:0] act, exp;

      for (int i = 0; i < 16; i++) begin
         mem1[i] = 16'h8000;
         mem2[i] = 16'h8000;
      end
      mem1[0] = 16'h0011;
      mem1[1] = 16'h4002;
      mem1[2] = 16'h8000;

      // CMD 0x11 N=0, DELAY 2 (8 cycles at DELAY_UNIT=4), END; one record per cycle
      vt[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      vt[1]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      vt[2]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      vt[3]  = mk(1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      vt[4]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
      vt[5]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
      for (int i = 6; i < 14; i++)
         vt[i] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
      vt[14] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
      vt[15] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
      vt[16] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
      vt[17] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);

      repeat (3) @(negedge clk);
      chk("reset_state_lat1", {v1, f1, l1, b1, d1, e1, addr1, cs1}, 32'd0);
      chk("reset_state_lat2", {v2, f2, l2, b2, d2, e2, addr2, cs2}, 32'd0);
      rst_n = 1'b1;
      tx_ready = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         act = {m_valid, vt[i].valid ? m_data : 8'h00, vt[i].valid ? m_first : 1'b0,
                vt[i].valid ? m_last : 1'b0, m_busy, m_done, m_err, m_addr};
         exp = {vt[i].valid, vt[i].data, vt[i].first, vt[i].last, vt[i].busy, vt[i].done,
                vt[i].err, vt[i].addr};
         if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d: actual %h required %h", i, act, exp);
         end
         n_vec++;
         start    = vt[i].start;
         tx_ready = vt[i].ready;
      end
      start = 1'b0;
`ifdef PANEL_INIT_SEQ_CHECKSUM_EN
      chk("csum_single", {24'd0, m_csum}, 32'h11);
`endif

      // Parameterised command with tx_ready toggling every cycle
      load_param_table(1'b0);
      run_stream(1'b1, 100);
      check_b0_stream("stall_lat1");
`ifdef PANEL_INIT_SEQ_CHECKSUM_EN
      chk("csum_lat1", {24'd0, m_csum}, 32'h96);
`endif

      // Reserved opcode: error one cycle after DECODE, nothing sent
      mem1[0] = 16'hC000;
      @(negedge clk);
      start = 1'b1; tx_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("op3_fetch", {28'd0, m_valid, m_busy, m_done, m_err}, {28'd0, 4'b0100});
      @(negedge clk);
      chk("op3_decode", {28'd0, m_valid, m_busy, m_done, m_err}, {28'd0, 4'b0100});
      @(negedge clk);
      chk("op3_err", {28'd0, m_valid, m_busy, m_done, m_err}, {28'd0, 4'b0101});
      @(negedge clk);
      chk("op3_idle", {28'd0, m_valid, m_busy, m_done, m_err}, {28'd0, 4'b0001});

      // Table overrun: 16 CMD entries, no END
      for (int i = 0; i < 16; i++) mem1[i] = 16'h002A;
      run_stream(1'b0, 200);
      chk("overrun_nbytes", nb, 16);
      chk("overrun_last_byte", {22'd0, got[15]}, {22'd0, 8'h2A, 1'b1, 1'b1});
      chk("overrun_flags", {30'd0, m_done, m_err}, {30'd0, 1'b0, 1'b1});
      chk("overrun_addr", {28'd0, m_addr}, 32'd15);

      // Reset in the middle of a parameter byte
      load_param_table(1'b0);
      @(negedge clk);
      start = 1'b1; tx_ready = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (m_valid && !m_first) break;
      end
      tx_ready = 1'b0;
      chk("reached_param", {31'd0, m_valid && !m_first}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_mid_packet", {25'd0, m_valid, m_busy, m_done, m_err, m_addr},
          {25'd0, 3'b000, 1'b0, 4'd0});
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {29'd0, m_busy, m_done, m_err}, 32'd0);
      run_stream(1'b0, 100);
      check_b0_stream("replay");

      // RD_LATENCY=2 instance, same table and toggling ready
      sel = 1'b1;
      load_param_table(1'b1);
      run_stream(1'b1, 100);
      check_b0_stream("stall_lat2");
`ifdef PANEL_INIT_SEQ_CHECKSUM_EN
      chk("csum_lat2", {24'd0, m_csum}, 32'h96);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
